// File: rtl/piano_pkg.sv
// Shared definitions for the piano voice path: note increments, sequencer states
// and constant helpers used by the wavetable synthesiser and its ROM.
package piano_pkg;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, OUT} state_t;

  // Phase increments for 16-bit accumulators at ~48.8 kHz sample rate, C4..D6.
  localparam logic [15:0] NOTE_INC [16] = '{
    16'd351,  16'd394,  16'd442,  16'd469,  16'd526,  16'd591,  16'd663,  16'd702,
    16'd788,  16'd885,  16'd937,  16'd1052, 16'd1181, 16'd1326, 16'd1405, 16'd1577
  };

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // First quadrant of a 64-point sine, amplitude 127, points 0..16.
  function automatic int sine_quarter(input int i);
    case (i)
      0:  return 0;
      1:  return 12;
      2:  return 25;
      3:  return 37;
      4:  return 49;
      5:  return 60;
      6:  return 71;
      7:  return 81;
      8:  return 90;
      9:  return 98;
      10: return 106;
      11: return 112;
      12: return 117;
      13: return 122;
      14: return 125;
      15: return 126;
      default: return 127;
    endcase
  endfunction

  // Full-cycle sine built from quadrant symmetry, scaled to the sample width.
  function automatic int sine_sample(input int idx, input int aw, input int w);
    int quad;
    int pos;
    int p16;
    int mag;
    quad = (idx >> (aw - 2)) & 3;
    pos  = idx & ((1 << (aw - 2)) - 1);
    p16  = (aw >= 6) ? (pos >> (aw - 6)) : (pos << (6 - aw));
    case (quad)
      0:       mag =  sine_quarter(p16);
      1:       mag =  sine_quarter(16 - p16);
      2:       mag = -sine_quarter(p16);
      default: mag = -sine_quarter(16 - p16);
    endcase
    return (mag * ((1 << (w - 1)) - 1)) / 127;
  endfunction

endpackage

// File: rtl/wave_rom.sv
// Single-cycle registered wave ROM shared by all voices; WAVE_SEL picks sine or square.
module wave_rom
  import piano_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int LUT_AW   = 6,
  parameter int WAVE_SEL = 0
) (
  input  logic                       clk,
  input  logic [LUT_AW-1:0]          addr,
  output logic signed [SAMPLE_W-1:0] data
);

  localparam logic signed [SAMPLE_W-1:0] SQ_HI = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W-1:0] SQ_LO = {1'b1, {(SAMPLE_W-1){1'b0}}};

  // NOTE: the ROM output register has no reset; its content only matters when the
  // read flag that travels beside it is set, and that flag is reset.
  always_ff @(posedge clk) begin
    if (WAVE_SEL == 0) data <= SAMPLE_W'(sine_sample(int'(addr), LUT_AW, SAMPLE_W));
    else               data <= addr[LUT_AW-1] ? SQ_LO : SQ_HI;
  end

endmodule

// File: rtl/poly_wavetable_synth.sv
// Polyphonic wavetable synthesiser: per sample tick, walks all voices through one
// shared ROM, mixes them and emits an offset-binary sample to the DAC stage.
module poly_wavetable_synth
  import piano_pkg::*;
#(
  parameter int N_KEYS     = 8,
  parameter int SAMPLE_W   = 8,
  parameter int PHASE_W    = 16,
  parameter int LUT_AW     = 6,
  parameter int SAMPLE_DIV = 1024,
  parameter int WAVE_SEL   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_KEYS-1:0]   keys,
  input  logic                mix_mode,
  output logic [SAMPLE_W-1:0] wave,
  output logic                wave_valid,
  output logic                clip,
  output logic                busy
);

  localparam int IDX_W = clog2(N_KEYS);
  localparam int ACC_W = SAMPLE_W + IDX_W;
  localparam int DIV_W = (SAMPLE_DIV > 1) ? clog2(SAMPLE_DIV) : 1;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (SAMPLE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  state_t                      state, state_nx;
  logic [DIV_W-1:0]            div;
  logic                        tick;
  logic [N_KEYS-1:0]           key_q;
  logic                        mode_q;
  logic [IDX_W-1:0]            idx;
  logic                        last;
  logic                        start;
  logic                        rd_valid;
  logic [PHASE_W-1:0]          phase [N_KEYS];
  logic [LUT_AW-1:0]           rom_addr;
  logic signed [SAMPLE_W-1:0]  rom_data;
  logic signed [ACC_W-1:0]     rom_ext;
  logic signed [ACC_W-1:0]     acc;
  logic signed [ACC_W-1:0]     shifted;
  logic [SAMPLE_W-1:0]         result;
  logic                        clip_nx;

  assign tick     = (div == DIV_W'(SAMPLE_DIV - 1));
  assign rom_addr = phase[idx][PHASE_W-1 -: LUT_AW];
  assign rom_ext  = {{(ACC_W-SAMPLE_W){rom_data[SAMPLE_W-1]}}, rom_data};

  always_ff @(posedge clk) begin
    if (rst || tick) div <= '0;
    else             div <= div + 1'b1;
  end

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (tick) state_nx = READ;
      READ:    if (last) state_nx = DRAIN;
      DRAIN:   state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    start = (state == IDLE) && tick;
    last  = (idx == IDX_W'(N_KEYS - 1));
  end

  wave_rom #(
    .SAMPLE_W (SAMPLE_W),
    .LUT_AW   (LUT_AW),
    .WAVE_SEL (WAVE_SEL)
  ) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  // A released voice parks at phase 0 so a re-press starts the cycle afresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_KEYS; k++) phase[k] <= '0;
    end else if (state == READ) begin
      phase[idx] <= key_q[idx] ? phase[idx] + PHASE_W'(NOTE_INC[idx]) : '0;
    end
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    result  = acc[SAMPLE_W-1:0];
    clip_nx = 1'b0;
    shifted = acc >>> IDX_W;
    if (mode_q) begin
      result = shifted[SAMPLE_W-1:0];
    end else if (acc > SAT_HI) begin
      result  = SAT_HI[SAMPLE_W-1:0];
      clip_nx = 1'b1;
    end else if (acc < SAT_LO) begin
      result  = SAT_LO[SAMPLE_W-1:0];
      clip_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q      <= '0;
      mode_q     <= 1'b0;
      idx        <= '0;
      rd_valid   <= 1'b0;
      acc        <= '0;
      wave       <= {1'b1, {(SAMPLE_W-1){1'b0}}};
      wave_valid <= 1'b0;
      clip       <= 1'b0;
    end else begin
      wave_valid <= 1'b0;
      rd_valid   <= (state == READ) && key_q[idx];
      if (start) begin
        key_q  <= keys;
        mode_q <= mix_mode;
        idx    <= '0;
        acc    <= '0;
      end else if (rd_valid) begin
        acc <= acc + rom_ext;
      end
      if (state == READ) idx <= idx + 1'b1;
      if (state == OUT) begin
        wave       <= {~result[SAMPLE_W-1], result[SAMPLE_W-2:0]};
        clip       <= clip_nx;
        wave_valid <= 1'b1;
      end
    end
  end

endmodule
